led_pattern_sequencer: RTL and testbench

Downstream consumer of the slow clock produced by the divider. It edge-detects the divided square wave in the system clock domain and advances one of four LED display patterns (off, chase, bounce, fill) by one step per slow-clock rising edge. It drives the board LED bank directly. Mode and pause come from board switches and are synchronised internally.

---
 rtl/led_pattern_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Steps one of four LED patterns (off, chase, bounce, fill) once per rising
//   edge of a divided square wave. The square wave is sampled as data in the
//   i_clk domain. The mode and pause switches are synchronised internally.
//
// Ports
//   i_clk       system clock, the only clock
//   i_rst       asynchronous active-high reset
//   i_slow_clk  divided square wave, already registered in the i_clk domain
//   i_mode      pattern select (asynchronous): 00 off, 01 chase, 10 bounce, 11 fill
//   i_pause     hold pattern while high (asynchronous)
//   o_led       LED drive, registered
//   o_step      one-cycle pulse per pattern advance, registered
//
// Mode table (active_mode)
//   MODE_OFF    | all LEDs dark, ticks still pulse o_step
//   MODE_CHASE  | single lit LED walks up and wraps from MSB to bit0
//   MODE_BOUNCE | single lit LED sweeps up then down, end LEDs shown once per turn
//   MODE_FILL   | lowest pos LEDs lit, pos = 0..N, then wraps to dark
module led_pattern_sequencer #(
    parameter int p_LED_COUNT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_slow_clk,
    input  logic [1:0]             i_mode,
    input  logic                   i_pause,
    output logic [p_LED_COUNT-1:0] o_led,
    output logic                   o_step
);

    // pos must be able to hold p_LED_COUNT itself for the all-ones fill step
    localparam int POS_W = $clog2(p_LED_COUNT + 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(p_LED_COUNT - 1);
    localparam logic [POS_W-1:0] POS_FULL = POS_W'(p_LED_COUNT);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    logic [1:0]             mode_meta;
    logic [1:0]             mode_sync;
    logic                   pause_meta;
    logic                   pause_sync;
    logic                   slow_prev;
    logic                   tick;
    mode_t                  active_mode;
    mode_t                  mode_req;
    logic [POS_W-1:0]       pos;
    logic [POS_W-1:0]       pos_next;
    logic                   dir;
    logic                   dir_next;
    logic [p_LED_COUNT-1:0] led_next;

    function automatic logic [p_LED_COUNT-1:0] one_hot(input logic [POS_W-1:0] p);
        logic [p_LED_COUNT-1:0] r;
        for (int i = 0; i < p_LED_COUNT; i++) begin
            r[i] = (POS_W'(i) == p);
        end
        return r;
    endfunction

    function automatic logic [p_LED_COUNT-1:0] low_mask(input logic [POS_W-1:0] p);
        logic [p_LED_COUNT-1:0] r;
        for (int i = 0; i < p_LED_COUNT; i++) begin
            r[i] = (POS_W'(i) < p);
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_meta  <= 2'b00;
            mode_sync  <= 2'b00;
            pause_meta <= 1'b0;
            pause_sync <= 1'b0;
            slow_prev  <= 1'b0;
        end else begin
            mode_meta  <= i_mode;
            mode_sync  <= mode_meta;
            pause_meta <= i_pause;
            pause_sync <= pause_meta;
            slow_prev  <= i_slow_clk;
        end
    end

    assign tick     = i_slow_clk & ~slow_prev;
    assign mode_req = mode_t'(mode_sync);

    always_comb begin
        pos_next = pos;
        dir_next = dir;
        led_next = '0;
        unique case (active_mode)
            MODE_CHASE: begin
                pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
                led_next = one_hot(pos_next);
            end
            MODE_BOUNCE: begin
                // direction flips on arrival at an end so the end LED is shown once
                if (!dir) begin
                    pos_next = pos + 1'b1;
                    if (pos_next == POS_LAST) dir_next = 1'b1;
                end else begin
                    pos_next = pos - 1'b1;
                    if (pos_next == '0) dir_next = 1'b0;
                end
                led_next = one_hot(pos_next);
            end
            MODE_FILL: begin
                pos_next = (pos == POS_FULL) ? '0 : pos + 1'b1;
                led_next = low_mask(pos_next);
            end
            default: begin
                pos_next = '0;
                dir_next = 1'b0;
                led_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            active_mode <= MODE_OFF;
            pos         <= '0;
            dir         <= 1'b0;
            o_led       <= '0;
            o_step      <= 1'b0;
        end else begin
            o_step <= 1'b0;
            if (mode_req != active_mode) begin
                // mode load wins over pause and swallows a coincident tick
                active_mode <= mode_req;
                pos         <= '0;
                dir         <= 1'b0;
                if (mode_req == MODE_CHASE || mode_req == MODE_BOUNCE) begin
                    o_led <= one_hot('0);
                end else begin
                    o_led <= '0;
                end
            end else if (!pause_sync && tick) begin
                pos    <= pos_next;
                dir    <= dir_next;
                o_led  <= led_next;
                o_step <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         slow_clk;
    logic [1:0]   mode;
    logic         pause;
    logic [N-1:0] led;
    logic         step;

    int n_err    = 0;
    int n_checks = 0;
    int step_cnt = 0;

    // reference model: mode, number of accepted steps since load, pause
    int m_mode  = 0;
    int m_k     = 0;
    bit m_pause = 1'b0;

    led_pattern_sequencer #(.p_LED_COUNT(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_slow_clk (slow_clk),
        .i_mode     (mode),
        .i_pause    (pause),
        .o_led      (led),
        .o_step     (step)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (step === 1'b1) step_cnt++;

    function automatic logic [31:0] model_led(input int md, input int k);
        longint p;
        longint q;
        case (md)
            1: model_led = 32'(64'd1 << (k % N));
            2: begin
                p = k % (2 * N - 2);
                q = (p < N) ? p : (2 * N - 2 - p);
                model_led = 32'(64'd1 << q);
            end
            3: begin
                p = k % (N + 1);
                model_led = 32'((64'd1 << p) - 1);
            end
            default: model_led = 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input string tag);
        int h;
        int l;
        @(negedge clk);
        slow_clk = 1'b1;
        @(posedge clk);
        #1;
        if (!m_pause) m_k++;
        chk({tag, "_led"}, 32'(led), model_led(m_mode, m_k));
        chk({tag, "_step"}, 32'(step), m_pause ? 32'd0 : 32'd1);
        h = $urandom_range(0, 3);
        l = $urandom_range(1, 4);
        repeat (h) @(negedge clk);
        @(negedge clk);
        slow_clk = 1'b0;
        repeat (l) @(negedge clk);
        chk({tag, "_step_clr"}, 32'(step), 32'd0);
    endtask

    task automatic set_mode(input int md, input string tag);
        @(negedge clk);
        mode = 2'(md);
        repeat (3) @(posedge clk);
        #1;
        if (md != m_mode) begin
            m_mode = md;
            m_k    = 0;
        end
        chk(tag, 32'(led), model_led(m_mode, m_k));
    endtask

    task automatic set_pause(input bit v);
        @(negedge clk);
        pause = v;
        repeat (3) @(negedge clk);
        m_pause = v;
    endtask

    initial begin
        int s0;
        int r;
        rst      = 1'b1;
        slow_clk = 1'b0;
        mode     = 2'b00;
        pause    = 1'b0;
        #1;
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_step", 32'(step), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // CHASE wrap and pulse count
        set_mode(1, "chase_load");
        chk("chase_init", 32'(led), 32'h0001);
        s0 = step_cnt;
        for (int i = 1; i <= 16; i++) do_tick($sformatf("chase_%0d", i));
        chk("chase_step_count", 32'(step_cnt - s0), 32'd16);

        // BOUNCE ends
        set_mode(2, "bounce_load");
        for (int i = 1; i <= 32; i++) do_tick($sformatf("bounce_%0d", i));

        // FILL
        set_mode(3, "fill_load");
        for (int i = 1; i <= 18; i++) do_tick($sformatf("fill_%0d", i));

        // pause in CHASE at 0x0010
        set_mode(1, "chase2_load");
        for (int i = 1; i <= 4; i++) do_tick($sformatf("chase2_%0d", i));
        chk("pause_start", 32'(led), 32'h0010);
        set_pause(1'b1);
        s0 = step_cnt;
        for (int i = 1; i <= 5; i++) do_tick($sformatf("paused_%0d", i));
        chk("paused_led", 32'(led), 32'h0010);
        chk("paused_no_step", 32'(step_cnt - s0), 32'd0);
        set_pause(1'b0);
        do_tick("unpause");
        chk("unpause_led", 32'(led), 32'h0020);

        // mode change coincident with a tick
        for (int i = 1; i <= 3; i++) do_tick($sformatf("chase3_%0d", i));
        chk("coinc_start", 32'(led), 32'h0100);
        @(negedge clk);
        mode = 2'b11;
        repeat (2) @(negedge clk);
        slow_clk = 1'b1;
        @(posedge clk);
        #1;
        chk("coinc_led", 32'(led), 32'h0000);
        chk("coinc_step", 32'(step), 32'd0);
        m_mode = 3;
        m_k    = 0;
        @(negedge clk);
        slow_clk = 1'b0;
        repeat (2) @(negedge clk);
        do_tick("coinc_next");
        chk("coinc_next_led", 32'(led), 32'h0001);

        // async reset mid-BOUNCE, dir down at 0x0400
        set_mode(2, "bounce2_load");
        for (int i = 1; i <= 20; i++) do_tick($sformatf("bounce2_%0d", i));
        chk("rst_start", 32'(led), 32'h0400);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_led", 32'(led), 32'd0);
        chk("rst_async_step", 32'(step), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        m_mode = 0;
        m_k    = 0;
        s0     = step_cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rel_2", 32'(led), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rel_3", 32'(led), 32'h0001);
        m_mode = 2;
        m_k    = 0;
        @(negedge clk);
        chk("rst_rel_no_step", 32'(step_cnt - s0), 32'd0);
        do_tick("rst_first_tick");
        chk("rst_first_led", 32'(led), 32'h0002);

        // randomized mix of mode changes, pause toggles and ticks
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) set_mode($urandom_range(0, 3), $sformatf("rnd_mode_%0d", i));
            else if (r == 1) set_pause(~m_pause);
            else do_tick($sformatf("rnd_tick_%0d", i));
        end
        set_pause(1'b0);

        // OFF still pulses o_step
        set_mode(0, "off_load");
        s0 = step_cnt;
        for (int i = 1; i <= 3; i++) do_tick($sformatf("off_%0d", i));
        chk("off_step_count", 32'(step_cnt - s0), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
